mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences a single-port, fixed-latency unified memory between two requesters of the accumulator CPU: the instruction-fetch side (driven by the program counter) and the data side (memory fetch/store stage). It accepts one request at a time, issues a registered memory command, and returns read data with a valid pulse to the owning requester. Sits between the CPU stages and the memory macro, replacing direct memory wiring.

## Interface
- `MEMORY_SIZE`, 2048: number of words; addresses at or above this are out of range.
- `ADDR_W`, 12: address width.
- `DATA_W`, 16: data width.
- `MEM_LATENCY`, 1: memory read latency in cycles; legal range 1..4.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_req` in 1: instruction fetch request; held high until `i_gnt`.
- `i_addr` in ADDR_W: fetch address; stable while `i_req`.
- `i_gnt` out 1: one-cycle grant pulse to fetch side.
- `i_rvalid` out 1: one-cycle fetch data valid.
- `i_rdata` out DATA_W: fetch data; valid with `i_rvalid`.
- `d_req` in 1: data request; held high until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load; stable while `d_req`.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_gnt` out 1: one-cycle grant pulse to data side.
- `d_rvalid` out 1: one-cycle load data valid (never for stores).
- `d_rdata` out DATA_W: load data.
- `mem_en` out 1: memory command strobe, one cycle per access.
- `mem_we` out 1: memory write enable, qualified by `mem_en`.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid MEM_LATENCY cycles after `mem_en`.
- `busy` out 1: high whenever state is not IDLE.
- `err` out 1: one-cycle pulse on out-of-range access.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: requests sampled only here. If any `*_req`, winner chosen, its address/data/we latched, state -> ISSUE.
- ISSUE: `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` driven from latched values, winner's `*_gnt` pulses. Store -> IDLE. Load -> WAIT with counter = MEM_LATENCY.
- WAIT: counter decrements each cycle; at zero `mem_rdata` registered into winner's `*_rdata`, winner's `*_rvalid` pulses next cycle, state -> IDLE.
- Out-of-range address (>= MEMORY_SIZE): ISSUE pulses `*_gnt` and `err`, `mem_en` stays 0; load still produces `*_rvalid` with `*_rdata` = 0 after the normal latency; store returns to IDLE.
- `*_rdata` holds its value between `*_rvalid` pulses.
- Reset (asserted any time, including mid-WAIT): state IDLE, every output 0, latched owner/counter cleared, in-flight read discarded (no `*_rvalid` after release). Owner-history register resets to DATA.

## Timing
- Request sampled in IDLE at cycle N -> `mem_en` and `*_gnt` in N+1.
- Load: `mem_rdata` valid in N+1+MEM_LATENCY; `*_rvalid` in N+2+MEM_LATENCY; next IDLE sample in N+2+MEM_LATENCY.
- Store: next IDLE sample in N+2; back-to-back stores give `mem_en` every 2 cycles.
- Requester drops `req` in the cycle after `gnt`; a `req` still high in the following IDLE cycle is a new request.
- Both `i_req` and `d_req` high in IDLE: resolved by the arbitration policy; loser stays pending, no grant to it this access.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin; on tie the side not granted last wins; history updated on every grant; first tie after reset grants instruction side.
- Undefined: fixed priority, data side always wins ties; history register not implemented.

## Test plan
- Single fetch, MEM_LATENCY=1, `i_addr`=0x010, memory word 0xBEEF -> `i_gnt` at N+1, `mem_en`=1 `mem_we`=0 `mem_addr`=0x010, `i_rvalid` with 0xBEEF at N+3.
- Store `d_addr`=0x7FF `d_wdata`=0x1234 then load 0x7FF -> `mem_we`=1 once, load returns 0x1234, `d_rvalid` never pulses for the store.
- Both requests held continuously, 4 accesses: round-robin build -> grants I,D,I,D; fixed build -> D,D,D,D while `d_req` held, I granted only after `d_req` drops.
- Load `d_addr`=0x800 (MEMORY_SIZE=2048) -> `err` and `d_gnt` pulse, `mem_en` stays 0, `d_rvalid` with 0x0000.
- MEM_LATENCY=4, assert `rst`=0 during WAIT -> all outputs 0 immediately, no `i_rvalid`/`d_rvalid` after release, `busy`=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the request/response handshakes of the fetch and data requesters,
// the single-port memory command/response bus and the status flags of the
// memory port arbiter.
//   slave  : view taken by mem_port_arbiter (consumes requests, drives memory)
//   master : view taken by the surrounding CPU stages and the memory macro
// Signals:
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata        instruction-fetch side
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata   data side
//   mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata  memory macro
//   busy, err                                      status
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              err;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, err
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// and data requesters. One access is in flight at a time: a request sampled
// in IDLE is latched, issued as a registered memory command in ISSUE (with a
// grant pulse to the winner) and, for loads, its data is returned with a
// one-cycle rvalid pulse after MEM_LATENCY cycles of WAIT.
// Out-of-range addresses (>= MEMORY_SIZE) are granted and flagged on err but
// never reach the memory; such loads return zero after the normal latency.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mem_port_arbiter_if.slave (requesters, memory, busy/err)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> round-robin tie-break (first tie -> fetch)
//                       undefined -> fixed priority, data side wins ties
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MEMORY_SIZE = 2048,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [2:0] LAT_C   = 3'(MEM_LATENCY);
    localparam logic       OWN_D   = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;   // 1 = data side owns the access
    logic              we_q, we_d;
    logic              oor_q, oor_d;
    logic [2:0]        cnt_q, cnt_d;

    logic              i_gnt_q, i_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              err_q, err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;

    logic              any_req_s;
    logic              pick_d_s;
    logic              sel_we_s;
    logic              sel_oor_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] load_data_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;   // side granted most recently (1 = data)

    // Tie goes to the side that was not granted last
    always_comb begin
        if (bus.i_req && bus.d_req) begin
            pick_d_s = (last_q != OWN_D);
        end else begin
            pick_d_s = bus.d_req;
        end
    end

    // History follows every grant decision taken in IDLE
    always_comb begin
        if ((state_q == S_IDLE) && any_req_s) begin
            last_d = pick_d_s;
        end else begin
            last_d = last_q;
        end
    end

    // History register; resetting to data makes the first tie go to fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= OWN_D;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: the data side wins any tie
    always_comb begin
        pick_d_s = bus.d_req;
    end
`endif

    // Select the winner's command and range-check its address
    always_comb begin
        any_req_s = bus.i_req | bus.d_req;
        if (pick_d_s) begin
            sel_addr_s = bus.d_addr;
            sel_we_s   = bus.d_we;
        end else begin
            sel_addr_s = bus.i_addr;
            sel_we_s   = 1'b0;
        end
        sel_oor_s = (32'(sel_addr_s) >= MEMORY_SIZE);
        if (oor_q) begin
            load_data_s = {DATA_W{1'b0}};
        end else begin
            load_data_s = bus.mem_rdata;
        end
    end

    // Sequencer next state; every output is a registered copy of its _d
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        oor_d       = oor_q;
        cnt_d       = cnt_q;
        i_gnt_d     = 1'b0;
        d_gnt_d     = 1'b0;
        err_d       = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rvalid_d  = 1'b0;
        d_rvalid_d  = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (any_req_s) begin
                    // Grant and command are set up now so they appear in ISSUE
                    owner_d    = pick_d_s;
                    we_d       = sel_we_s;
                    oor_d      = sel_oor_s;
                    i_gnt_d    = ~pick_d_s;
                    d_gnt_d    = pick_d_s;
                    err_d      = sel_oor_s;
                    mem_en_d   = ~sel_oor_s;
                    mem_we_d   = ~sel_oor_s & sel_we_s;
                    mem_addr_d = sel_addr_s;
                    if (pick_d_s) begin
                        mem_wdata_d = bus.d_wdata;
                    end else begin
                        mem_wdata_d = mem_wdata_q;
                    end
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = LAT_C;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Counter reaches zero in the cycle mem_rdata is valid
                if (cnt_q == 3'd1) begin
                    if (owner_q == OWN_D) begin
                        d_rdata_d  = load_data_s;
                        d_rvalid_d = 1'b1;
                    end else begin
                        i_rdata_d  = load_data_s;
                        i_rvalid_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            cnt_q       <= 3'd0;
            i_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            i_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            i_rdata_q   <= {DATA_W{1'b0}};
            d_rdata_q   <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            cnt_q       <= cnt_d;
            i_gnt_q     <= i_gnt_d;
            d_gnt_q     <= d_gnt_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rvalid_q  <= i_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.i_gnt     = i_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.err       = err_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rvalid  = i_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst;
    logic rst4;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();

    mem_port_arbiter #(.MEMORY_SIZE(2048), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mem_port_arbiter #(.MEMORY_SIZE(2048), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(4)) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    // Memory model, latency 1: data of a read shows up the cycle after mem_en
    logic [15:0] mem1 [0:2047];
    logic [15:0] rd1_q;
    logic        rv1_q;
    always @(posedge clk) begin
        rv1_q <= 1'b0;
        if (bus1.mem_en) begin
            if (bus1.mem_we) begin
                mem1[bus1.mem_addr[10:0]] <= bus1.mem_wdata;
            end else begin
                rd1_q <= mem1[bus1.mem_addr[10:0]];
                rv1_q <= 1'b1;
            end
        end
    end
    assign bus1.mem_rdata = rv1_q ? rd1_q : 16'hDEAD;

    // Memory model, latency 4: read data travels a 4-deep pipeline
    logic [15:0] mem4 [0:2047];
    logic [15:0] rd4 [0:3];
    logic        rv4 [0:3];
    always @(posedge clk) begin
        rv4[0] <= 1'b0;
        if (bus4.mem_en) begin
            if (bus4.mem_we) begin
                mem4[bus4.mem_addr[10:0]] <= bus4.mem_wdata;
            end else begin
                rd4[0] <= mem4[bus4.mem_addr[10:0]];
                rv4[0] <= 1'b1;
            end
        end
        for (int k = 1; k < 4; k++) begin
            rd4[k] <= rd4[k-1];
            rv4[k] <= rv4[k-1];
        end
    end
    assign bus4.mem_rdata = rv4[3] ? rd4[3] : 16'hDEAD;

    typedef struct {
        logic        i_req;
        logic [11:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [11:0] d_addr;
        logic [15:0] d_wdata;
        logic        e_i_gnt;
        logic        e_d_gnt;
        logic        e_err;
        logic        e_mem_en;
        logic        e_mem_we;
        logic [11:0] e_mem_addr;
        logic        e_rv_i;
        logic        e_rv_d;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vecs [10];

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rvi_mask;
        logic [3:0]  rvd_mask;
        logic [3:0]  gseq;
        int          ng;
        logic        both;
        logic        seen;
        logic [7:0]  en_pat;
        logic [7:0]  we_pat;
        logic        bad;
        logic [9:0]  gnt_mask;
        logic [9:0]  rv_mask;
        vec_t        v;

        //            i_req i_addr    d_req d_we  d_addr    d_wdata    igt   dgt   err   en    we    mem_addr  rvi   rvd   rdata
        vecs[0] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h010, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h010, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h010, 1'b1, 1'b0, 16'hBEEF};
        vecs[2] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h7FF, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h7FF, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h7FF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h7FF, 1'b0, 1'b1, 16'h1234};
        vecs[4] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h800, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 16'h0000};
        vecs[5] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h800, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 16'h0000};
        vecs[7] = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h000, 16'hA5A5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 16'h0000};
        vecs[8] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 16'hA5A5};
        vecs[9] = '{1'b1, 12'h7FF, 1'b0, 1'b0, 12'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h7FF, 1'b1, 1'b0, 16'h1234};

        rst  = 1'b0;
        rst4 = 1'b0;
        bus1.i_req = 1'b0; bus1.i_addr = 12'h000; bus1.d_req = 1'b0;
        bus1.d_we = 1'b0; bus1.d_addr = 12'h000; bus1.d_wdata = 16'h0000;
        bus4.i_req = 1'b0; bus4.i_addr = 12'h000; bus4.d_req = 1'b0;
        bus4.d_we = 1'b0; bus4.d_addr = 12'h000; bus4.d_wdata = 16'h0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_flags", 32'({bus1.i_gnt, bus1.d_gnt, bus1.i_rvalid, bus1.d_rvalid,
                                bus1.mem_en, bus1.mem_we, bus1.busy, bus1.err}), 32'd0);
        chk("reset_rdata", {bus1.i_rdata, bus1.d_rdata}, 32'd0);
        chk("reset_mem_bus", {4'd0, bus1.mem_addr, bus1.mem_wdata}, 32'd0);
        @(posedge clk); #1;
        rst  = 1'b1;
        rst4 = 1'b1;
        @(posedge clk); #1;

        // ---------------- table-driven single-requester accesses (latency 1)
        for (int n = 0; n < 10; n++) begin
            v = vecs[n];
            bus1.i_req = v.i_req; bus1.i_addr = v.i_addr;
            bus1.d_req = v.d_req; bus1.d_we = v.d_we;
            bus1.d_addr = v.d_addr; bus1.d_wdata = v.d_wdata;
            @(negedge clk);
            chk($sformatf("v%0d_busy_idle", n), 32'(bus1.busy), 32'd0);
            @(negedge clk);
            chk($sformatf("v%0d_i_gnt", n), 32'(bus1.i_gnt), 32'(v.e_i_gnt));
            chk($sformatf("v%0d_d_gnt", n), 32'(bus1.d_gnt), 32'(v.e_d_gnt));
            chk($sformatf("v%0d_err", n), 32'(bus1.err), 32'(v.e_err));
            chk($sformatf("v%0d_mem_en", n), 32'(bus1.mem_en), 32'(v.e_mem_en));
            chk($sformatf("v%0d_mem_we", n), 32'(bus1.mem_we), 32'(v.e_mem_we));
            chk($sformatf("v%0d_busy_issue", n), 32'(bus1.busy), 32'd1);
            if (v.e_mem_en) chk($sformatf("v%0d_mem_addr", n), 32'(bus1.mem_addr), 32'(v.e_mem_addr));
            if (v.e_mem_we) chk($sformatf("v%0d_mem_wdata", n), 32'(bus1.mem_wdata), 32'(v.d_wdata));
            @(posedge clk); #1;
            bus1.i_req = 1'b0;
            bus1.d_req = 1'b0;
            rvi_mask = 4'd0;
            rvd_mask = 4'd0;
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                rvi_mask[k] = bus1.i_rvalid;
                rvd_mask[k] = bus1.d_rvalid;
            end
            chk($sformatf("v%0d_i_rvalid_cycles", n), 32'(rvi_mask), v.e_rv_i ? 32'h4 : 32'h0);
            chk($sformatf("v%0d_d_rvalid_cycles", n), 32'(rvd_mask), v.e_rv_d ? 32'h4 : 32'h0);
            if (v.e_rv_i) chk($sformatf("v%0d_i_rdata", n), 32'(bus1.i_rdata), 32'(v.e_rdata));
            if (v.e_rv_d) chk($sformatf("v%0d_d_rdata", n), 32'(bus1.d_rdata), 32'(v.e_rdata));
            @(posedge clk); #1;
        end

        // ---------------- reset, then both requests held continuously
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_rdata_cleared", {bus1.i_rdata, bus1.d_rdata}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        bus1.i_req = 1'b1; bus1.i_addr = 12'h010;
        bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 12'h7FF;
        gseq = 4'd0;
        ng   = 0;
        both = 1'b0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (bus1.i_gnt && bus1.d_gnt) both = 1'b1;
            if (bus1.i_gnt || bus1.d_gnt) begin
                gseq[ng] = bus1.d_gnt;
                ng++;
            end
        end
        chk("tie_grant_count", 32'(ng), 32'd4);
        chk("tie_both_granted", 32'(both), 32'd0);
`ifdef ARB_ROUND_ROBIN_EN
        chk("tie_grant_order", 32'(gseq), 32'hA);
`else
        chk("tie_grant_order", 32'(gseq), 32'hF);
`endif
        @(posedge clk); #1;
        bus1.d_req = 1'b0;
        seen = 1'b0;
        bad  = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus1.d_gnt) bad = 1'b1;
            if (bus1.i_gnt) seen = 1'b1;
        end
        chk("fetch_after_d_drop", 32'(seen), 32'd1);
        chk("no_d_gnt_after_drop", 32'(bad), 32'd0);
        @(posedge clk); #1;
        bus1.i_req = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("tie_final_i_rdata", 32'(bus1.i_rdata), 32'hBEEF);
        chk("tie_final_d_rdata", 32'(bus1.d_rdata), 32'h1234);
        @(posedge clk); #1;

        // ---------------- back-to-back stores: mem_en every second cycle
        bus1.d_req = 1'b1; bus1.d_we = 1'b1; bus1.d_addr = 12'h100; bus1.d_wdata = 16'h7777;
        en_pat = 8'd0;
        we_pat = 8'd0;
        bad    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            en_pat[k] = bus1.mem_en;
            we_pat[k] = bus1.mem_we;
            if (bus1.d_rvalid || bus1.i_rvalid) bad = 1'b1;
        end
        @(posedge clk); #1;
        bus1.d_req = 1'b0;
        chk("b2b_mem_en_pattern", 32'(en_pat), 32'hAA);
        chk("b2b_mem_we_pattern", 32'(we_pat), 32'hAA);
        chk("b2b_no_rvalid", 32'(bad), 32'd0);
        repeat (3) @(posedge clk); #1;

        // ---------------- latency 4: store, then fetch timing
        bus4.d_req = 1'b1; bus4.d_we = 1'b1; bus4.d_addr = 12'h020; bus4.d_wdata = 16'h4C4C;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus4.d_gnt) bus4.d_req = 1'b0;
        end
        chk("l4_store_req_dropped", 32'(bus4.d_req), 32'd0);
        @(posedge clk); #1;
        bus4.i_req = 1'b1; bus4.i_addr = 12'h020;
        gnt_mask = 10'd0;
        rv_mask  = 10'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            gnt_mask[k] = bus4.i_gnt;
            rv_mask[k]  = bus4.i_rvalid;
            if (bus4.i_gnt) bus4.i_req = 1'b0;
        end
        chk("l4_i_gnt_cycle", 32'(gnt_mask), 32'h002);
        chk("l4_i_rvalid_cycle", 32'(rv_mask), 32'h040);
        chk("l4_i_rdata", 32'(bus4.i_rdata), 32'h4C4C);
        @(posedge clk); #1;

        // ---------------- latency 4: reset asserted during WAIT
        bus4.i_req = 1'b1; bus4.i_addr = 12'h020;
        @(negedge clk);
        @(negedge clk);
        chk("l4_rst_pre_gnt", 32'(bus4.i_gnt), 32'd1);
        bus4.i_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("l4_rst_busy_before", 32'(bus4.busy), 32'd1);
        rst4 = 1'b0;
        #1;
        chk("l4_rst_flags", 32'({bus4.i_gnt, bus4.d_gnt, bus4.i_rvalid, bus4.d_rvalid,
                                 bus4.mem_en, bus4.mem_we, bus4.busy, bus4.err}), 32'd0);
        chk("l4_rst_rdata", {bus4.i_rdata, bus4.d_rdata}, 32'd0);
        chk("l4_rst_mem_bus", {4'd0, bus4.mem_addr, bus4.mem_wdata}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst4 = 1'b1;
        bad  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus4.i_rvalid || bus4.d_rvalid) bad = 1'b1;
            if (bus4.busy) seen = 1'b1;
        end
        chk("l4_no_rvalid_after_rst", 32'(bad), 32'd0);
        chk("l4_idle_after_rst", 32'(seen), 32'd0);
        chk("l4_rdata_still_zero", 32'(bus4.i_rdata), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
